// File: rtl/bos_spi_pkg.sv
// Shared definitions for the SPI register responder.
//   spi_state_e : frame FSM states
//   FRAME_LEN   : bits per frame, HDR_LEN : header bits (R/nW + address)
//   RNW_BIT     : R/nW position in the frame, HDR_RNW : same bit within the header byte
//   addr_hit()  : true when a 3-bit frame address maps onto the register file
package bos_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } spi_state_e;

  localparam int FRAME_LEN = 16;
  localparam int HDR_LEN   = 8;
  localparam int RNW_BIT   = 15;
  localparam int HDR_RNW   = RNW_BIT - HDR_LEN;

  function automatic logic addr_hit(input logic [2:0] a, input int n);
    return int'(a) < n;
  endfunction

endpackage

// File: rtl/bos_sync_edge.sv
// One-bit synchronizer with rise/fall detection on the synchronized level.
//   clk_in, n_rst : system clock, async active-low reset (all flops clear to 0)
//   d             : asynchronous input pin
//   q             : synchronized level (STAGES flops deep)
//   rise, fall    : single-cycle pulses on q edges
module bos_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic n_rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev;

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= STAGES'({sync_q, d});
      prev   <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise =  q & ~prev;
  assign fall = ~q &  prev;

endmodule

// File: rtl/bos_spi_responder.sv
// Mode-0 SPI responder with a small 8-bit register file.
// Frame: 16 bits MSB first = {R/nW, addr[6:0] (only [2:0] used), data[7:0]}.
// Optional read-back path is built only when BOS_SPI_RDBK_EN is defined;
// otherwise sdatao/sdatao_oe are tied low and reads complete with no effect.
//   clk_in, n_rst       : system clock, async active-low reset
//   sck, sdatai, sel    : asynchronous SPI pins from the initiator
//   sdatao, sdatao_oe   : read data and its drive enable
//   wr_stb/addr/data    : one-cycle committed-write strobe
//   frame_err           : one-cycle pulse on aborted or overlong frame
//   regs_q              : flattened register file, register 0 in the LSBs
module bos_spi_responder
  import bos_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int REG_N       = 8
) (
  input  logic               clk_in,
  input  logic               n_rst,
  input  logic               sck,
  input  logic               sdatai,
  input  logic               sel,
  output logic               sdatao,
  output logic               sdatao_oe,
  output logic               wr_stb,
  output logic [2:0]         wr_addr,
  output logic [7:0]         wr_data,
  output logic               frame_err,
  output logic [8*REG_N-1:0] regs_q
);

  localparam int SW = $clog2(SYNC_STAGES + 1);

  // bit 0 = sck, bit 1 = sdatai, bit 2 = sel
  logic [2:0] pin_raw, pin_s, pin_rise, pin_fall;
  assign pin_raw = {sel, sdatai, sck};

  for (genvar g = 0; g < 3; g++) begin : g_sync
    bos_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
      .clk_in (clk_in),
      .n_rst  (n_rst),
      .d      (pin_raw[g]),
      .q      (pin_s[g]),
      .rise   (pin_rise[g]),
      .fall   (pin_fall[g])
    );
  end

  logic sck_rise, sck_fall, sdi, sel_s, sel_rise, sel_fall;
  assign sck_rise = pin_rise[0];
  assign sck_fall = pin_fall[0];
  assign sdi      = pin_s[1];
  assign sel_s    = pin_s[2];
  assign sel_rise = pin_rise[2];
  assign sel_fall = pin_fall[2];

  // The synchronizer clears to 0 on reset, so a sel held high across reset
  // would look like a rise. Wait until the chain reflects the pin, then
  // require sel to be seen low before any frame start is honoured.
  logic [SW-1:0] settle_cnt;
  logic          armed, start;

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      settle_cnt <= '0;
      armed      <= 1'b0;
    end else if (settle_cnt != SW'(SYNC_STAGES)) begin
      settle_cnt <= settle_cnt + SW'(1);
    end else if (!sel_s) begin
      armed <= 1'b1;
    end
  end

  assign start = armed & sel_rise;

  // frame FSM
  spi_state_e state;
  logic [4:0] bit_cnt;
  logic [7:0] rx_sh, rx_next, hdr;
  logic       extra_seen;

  assign rx_next = {rx_sh[6:0], sdi};

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      rx_sh      <= '0;
      hdr        <= '0;
      extra_seen <= 1'b0;
      wr_stb     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_err  <= 1'b0;
    end else begin
      wr_stb    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          // a coincident sck rise is the frame's first bit
          state      <= ST_HDR;
          extra_seen <= 1'b0;
          bit_cnt    <= sck_rise ? 5'd1 : 5'd0;
          if (sck_rise) rx_sh <= rx_next;
        end
        ST_HDR, ST_DATA: begin
          if (sel_fall) begin
            state     <= ST_IDLE;
            frame_err <= 1'b1;
          end else if (sck_rise) begin
            rx_sh   <= rx_next;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'(HDR_LEN - 1)) begin
              hdr   <= rx_next;
              state <= ST_DATA;
            end
            if (bit_cnt == 5'(FRAME_LEN - 1)) begin
              state <= ST_HOLD;
              if (!hdr[HDR_RNW] && addr_hit(hdr[2:0], REG_N)) begin
                wr_stb  <= 1'b1;
                wr_addr <= hdr[2:0];
                wr_data <= rx_next;
              end
            end
          end
        end
        ST_HOLD: begin
          if (sel_fall) begin
            state <= ST_IDLE;
          end else if (sck_rise && !extra_seen) begin
            extra_seen <= 1'b1;
            frame_err  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // register file
  logic [7:0] regs [REG_N];

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      for (int r = 0; r < REG_N; r++) regs[r] <= '0;
    end else if (wr_stb) begin
      for (int r = 0; r < REG_N; r++)
        if (wr_addr == 3'(r)) regs[r] <= wr_data;
    end
  end

  for (genvar r = 0; r < REG_N; r++) begin : g_regq
    assign regs_q[8*r +: 8] = regs[r];
  end

`ifdef BOS_SPI_RDBK_EN
  logic [7:0] tx_sh, rd_byte;
  logic       tx_load, tx_shift, tx_clear;

  // unmapped addresses read as zero
  always_comb begin
    rd_byte = '0;
    for (int r = 0; r < REG_N; r++)
      if (rx_next[2:0] == 3'(r)) rd_byte = regs[r];
  end

  assign tx_load  = (state == ST_HDR) && !sel_fall && sck_rise &&
                    (bit_cnt == 5'(HDR_LEN - 1)) && rx_next[HDR_RNW];
  assign tx_shift = (state == ST_DATA) && !sel_fall && sck_fall && hdr[HDR_RNW];
  // drive ends on abort, outside a frame, and on the 16th fall (first fall in HOLD)
  assign tx_clear = sel_fall || (state == ST_IDLE) || ((state == ST_HOLD) && sck_fall);

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      tx_sh     <= '0;
      sdatao    <= 1'b0;
      sdatao_oe <= 1'b0;
    end else begin
      if (tx_load) tx_sh <= rd_byte;
      if (tx_shift) begin
        sdatao    <= tx_sh[7];
        tx_sh     <= {tx_sh[6:0], 1'b0};
        sdatao_oe <= 1'b1;
      end else if (tx_clear) begin
        sdatao    <= 1'b0;
        sdatao_oe <= 1'b0;
      end
    end
  end
`else
  assign sdatao    = 1'b0;
  assign sdatao_oe = 1'b0;
`endif

  // sck level, sdatai edges and ignored address bits 14:11 are not needed
  logic unused_pins;
  assign unused_pins = ^{pin_s[0], pin_rise[1], pin_fall[1], hdr[6:3], sck_fall};

endmodule

// File: doc/bos_spi_responder.md
BOS_SPI_RESPONDER -- requirements
Module: bos_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on sck, sdatai and sel.
REQ-002 SHALL have parameter REG_N, default 8, giving the register-file depth (8-bit registers).
REQ-003 clk_in  input  1  system clock; all logic is on its rising edge.
REQ-004 n_rst  input  1  asynchronous, active-low reset.
REQ-005 sck  input  1  serial clock from the initiator (mode 0), asynchronous to clk_in.
REQ-006 sdatai  input  1  serial data from the initiator, MSB first.
REQ-007 sel  input  1  active-high select for this responder (one line of the initiator's sl bus).
REQ-008 sdatao  output  1  serial read data to the initiator.
REQ-009 sdatao_oe  output  1  high while this responder drives sdatao.
REQ-010 wr_stb  output  1  one-cycle pulse for a committed write.
REQ-011 wr_addr  output  3  address of the committed write, valid with wr_stb.
REQ-012 wr_data  output  8  data of the committed write, valid with wr_stb.
REQ-013 frame_err  output  1  one-cycle pulse for an aborted or overlong frame.
REQ-014 regs_q  output  8*REG_N  flattened register-file contents; register 0 is in the LSBs.

Function
REQ-015 SHALL pass sck, sdatai and sel through SYNC_STAGES flops, then edge-detect them; pin-to-action latency is SYNC_STAGES+1 clk_in cycles.
REQ-016 Operating limit: sck high and low times each >= SYNC_STAGES+2 clk_in cycles; the block SHALL operate correctly at that limit.
REQ-017 Frame format: 16 bits; bit15 = R/nW (1 = read); bits14:8 = address (bits10:8 used, bits14:11 ignored); bits7:0 = data.
REQ-018 Timing: sdatai is sampled on each synchronized sck rise; sdatao is updated on each synchronized sck fall.
REQ-019 FSM states: IDLE, HDR, DATA, HOLD.
REQ-020 IDLE->HDR on sel rise; bit counter cleared.
REQ-021 HDR->DATA after the 8th sampled bit; on the same cycle, for a read, the addressed register is loaded into the 8-bit tx shifter.
REQ-022 DATA->HOLD after the 16th sampled bit; for a write, wr_stb pulses on that cycle and the register updates on the next clk_in edge.
REQ-023 HOLD ignores further sck edges; an extra sampled bit pulses frame_err once per frame.
REQ-024 HOLD->IDLE on sel fall.
REQ-025 Read: sdatao_oe SHALL be 1 from the 8th-bit fall through the end of the frame; sdatao shifts the register MSB first, with the first bit presented on the 8th sck fall.
REQ-026 sdatao and sdatao_oe SHALL be 0 at all other times, including write frames.
REQ-027 Address >= REG_N: writes are dropped (no wr_stb); reads return 0x00.
REQ-028 sel fall in HDR or DATA SHALL abort the frame: no write, frame_err pulses, FSM goes to IDLE.
REQ-029 sel rise and an sck edge in the same cycle: the frame start is processed first, then the edge; for a mode-0 initiator the sck edge is a rise and is sampled as bit15.
REQ-030 wr_stb and frame_err SHALL never assert in the same cycle.

Reset
REQ-031 Reset SHALL force: FSM = IDLE; counters, shifters and all registers = 0; sdatao = 0; sdatao_oe = 0; wr_stb = 0; frame_err = 0.
REQ-032 Synchronizer flops SHALL reset to 0.
REQ-033 n_rst asserted mid-frame SHALL discard the frame.
REQ-034 After reset release, a frame SHALL be accepted only after a fresh sel rise.

Configuration
REQ-035 Macro BOS_SPI_RDBK_EN defined: reads behave per REQ-021 and REQ-025.
REQ-036 Macro BOS_SPI_RDBK_EN undefined: the tx shifter is not built; sdatao and sdatao_oe are tied to 0; read frames complete normally with no effect.

Structure
REQ-037 Package bos_spi_pkg SHALL hold the FSM state enum, FRAME_LEN = 16, HDR_LEN = 8 and the R/nW bit index.
REQ-038 Sub-module bos_sync_edge SHALL implement one synchronizer plus rise/fall detector, instantiated three times.

Verification
REQ-039 Write 0x03/0xA5 (frame 0x03A5): wr_stb one cycle with wr_addr 3 and wr_data 0xA5; regs_q[31:24] = 0xA5.
REQ-040 After REQ-039, read 0x83: sdatao bits 8..15 = 1,0,1,0,0,1,0,1; sdatao_oe high only over those bits.
REQ-041 sel dropped after 11 bits of write 0x02FF: frame_err pulses, no wr_stb, register 2 stays 0x00.
REQ-042 17-bit write 0x0111 plus one extra bit: one wr_stb (register 1 = 0x11), then one frame_err.
REQ-043 Write addr 5 = 0x3C, then n_rst pulse mid-frame of a write to addr 6: all regs 0; next valid frame accepted.
REQ-044 sck at the REQ-016 minimum with a random asynchronous phase across 200 frames: zero mismatches.
